// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB3 slave responder.
//   apb_state_e   : responder FSM states
//   DEF_*         : default parameter values
//   WAIT_CNT_W    : width of the wait-state counter (WAIT_CYCLES 0..15)
//   addr_in_range : true when a word address falls inside the implemented memory
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned DEF_ADDR_WIDTH  = 8;
    localparam int unsigned DEF_DATA_WIDTH  = 8;
    localparam int unsigned DEF_MEM_DEPTH   = 64;
    localparam int unsigned DEF_WAIT_CYCLES = 1;
    localparam int unsigned WAIT_CNT_W      = 4;

    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/apb_slave_mem.sv
// Word-addressed register memory behind the APB slave.
//   clk_i   : clock
//   rst_i   : synchronous active-high clear of every word
//   we_i    : write enable (out-of-range addresses are ignored)
//   waddr_i : write word address
//   wdata_i : write data
//   raddr_i : combinational read address (out-of-range reads return 0)
//   rdata_o : combinational read data
module apb_slave_mem
    import apb_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH  = DEF_MEM_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [IDX_W-1:0]      widx;
    logic [IDX_W-1:0]      ridx;
    logic                  waddr_ok;
    logic                  raddr_ok;

    assign widx     = IDX_W'(waddr_i);
    assign ridx     = IDX_W'(raddr_i);
    assign waddr_ok = addr_in_range(32'(waddr_i), MEM_DEPTH);
    assign raddr_ok = addr_in_range(32'(raddr_i), MEM_DEPTH);

    // Storage with synchronous clear; range guard keeps truncated indices from aliasing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && waddr_ok) begin
            mem_q[widx] <= wdata_i;
        end
    end

    assign rdata_o = raddr_ok ? mem_q[ridx] : '0;

endmodule

// File: rtl/apb_slave_responder.sv
// APB3 completer: tracks SETUP/ACCESS, inserts WAIT_CYCLES wait states and
// returns a registered PREADY/PRDATA/PSLVERR response from a word memory.
//   PCLK    : bus clock
//   PRESET  : synchronous active-high reset
//   PSEL    : slave select
//   PENABLE : access-phase indicator
//   PWRITE  : 1 = write, 0 = read
//   PADDR   : word address (>= MEM_DEPTH gives an error response)
//   PWDATA  : write data
//   PREADY  : high for exactly the completing cycle
//   PRDATA  : read data, held until the next read completes
//   PSLVERR : error flag, only ever high together with PREADY
module apb_slave_responder
    import apb_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    apb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic                  setup_err;
    logic                  resp_fire;
    logic                  resp_write;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] resp_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign setup_err = !addr_in_range(32'(PADDR), MEM_DEPTH);

    // With zero wait states the response is built on the capture edge itself,
    // so it must come from the live bus rather than the not-yet-loaded registers.
    assign resp_addr  = (state_q == IDLE) ? PADDR     : addr_q;
    assign resp_write = (state_q == IDLE) ? PWRITE    : write_q;
    assign resp_err   = (state_q == IDLE) ? setup_err : err_q;

    apb_slave_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .we_i    (mem_we),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .raddr_i (resp_addr),
        .rdata_o (mem_rdata)
    );

    // State and response registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Next-state and response logic. The state register trails the bus by one
    // cycle: SETUP is held during the master's first ACCESS cycle, which keeps
    // completion at 2+WAIT_CYCLES bus cycles.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = prdata_q;
        mem_we    = 1'b0;
        resp_fire = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d   = SETUP;
                    addr_d    = PADDR;
                    write_d   = PWRITE;
                    wdata_d   = PWDATA;
                    err_d     = setup_err;
                    cnt_d     = WAIT_CNT_W'(WAIT_CYCLES);
                    resp_fire = (WAIT_CYCLES == 0);
                end
            end
            SETUP, ACCESS: begin
                if (!PSEL) begin
                    // Abort: drop the transfer without a response or write.
                    state_d = IDLE;
                end else if (pready_q) begin
                    // Completion edge: commit only a fully handshaken in-range write.
                    mem_we  = PENABLE && write_q && !err_q;
                    state_d = IDLE;
                end else begin
                    state_d = ACCESS;
                    if (cnt_q <= WAIT_CNT_W'(1)) begin
                        cnt_d     = '0;
                        resp_fire = 1'b1;
                    end else begin
                        cnt_d = cnt_q - WAIT_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (resp_fire) begin
            pready_d  = 1'b1;
            pslverr_d = resp_err;
            if (!resp_write) begin
                prdata_d = resp_err ? '0 : mem_rdata;
            end
        end
    end

    assign PREADY  = pready_q;
    assign PRDATA  = prdata_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_responder.sv
// Bench for apb_slave_responder: three instances (WAIT_CYCLES = 1, 0, 3) share
// one APB bus, each with its own PSEL. Expected responses come from a bench-side
// memory model and are queued at SETUP, then popped when PREADY is seen.
module tb_apb_slave_responder;

    localparam int unsigned DEPTH = 64;
    localparam int NDUT = 3;
    localparam int I1   = 0;   // WAIT_CYCLES = 1
    localparam int I0   = 1;   // WAIT_CYCLES = 0
    localparam int I3   = 2;   // WAIT_CYCLES = 3

    logic       PCLK;
    logic       PRESET;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic       psel    [NDUT];
    logic       pready  [NDUT];
    logic       pslverr [NDUT];
    logic [7:0] prdata  [NDUT];

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        apb_slave_responder #(
            .ADDR_WIDTH  (8),
            .DATA_WIDTH  (8),
            .MEM_DEPTH   (DEPTH),
            .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .PCLK    (PCLK),
            .PRESET  (PRESET),
            .PSEL    (psel[g]),
            .PENABLE (PENABLE),
            .PWRITE  (PWRITE),
            .PADDR   (PADDR),
            .PWDATA  (PWDATA),
            .PREADY  (pready[g]),
            .PRDATA  (prdata[g]),
            .PSLVERR (pslverr[g])
        );
    end

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] model_mem [NDUT][DEPTH];
    logic [7:0] last_rd   [NDUT];
    int         checks = 0;
    int         fails  = 0;

    function automatic int wait_of(input int idx);
        return (idx == I1) ? 1 : ((idx == I0) ? 0 : 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < NDUT; d++) begin
            last_rd[d] = 8'h00;
            for (int a = 0; a < DEPTH; a++) model_mem[d][a] = 8'h00;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("%s_pready%0d", tag, d), 32'(pready[d]), 32'd0);
            chk($sformatf("%s_pslverr%0d", tag, d), 32'(pslverr[d]), 32'd0);
            chk($sformatf("%s_prdata%0d", tag, d), 32'(prdata[d]), 32'd0);
        end
    endtask

    // One full transfer on instance idx. Entered and left 1 ns after a posedge.
    // With b2b set the bus is left selected so the next call starts SETUP at once.
    task automatic xfer(input int idx, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wdata, input bit b2b);
        exp_t e;
        exp_t got;
        int   cyc;
        bit   done;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        e.err   = (32'(addr) >= DEPTH);
        if (wr)         e.rdata = last_rd[idx];
        else if (e.err) e.rdata = 8'h00;
        else            e.rdata = model_mem[idx][addr[5:0]];
        sb.push_back(e);

        psel[idx] = 1'b1;
        PENABLE   = 1'b0;
        PWRITE    = wr;
        PADDR     = addr;
        PWDATA    = wdata;
        @(negedge PCLK);
        chk($sformatf("setup_ready_low_%0d", idx), 32'(pready[idx]), 32'd0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        // Only the SETUP capture may be used; disturb the bus during ACCESS.
        PADDR   = ~addr;
        PWDATA  = ~wdata;
        cyc  = 1;
        done = 1'b0;
        while (!done) begin
            @(negedge PCLK);
            if (pready[idx] === 1'b1) begin
                got = sb.pop_front();
                chk($sformatf("latency_%0d", idx), 32'(cyc), 32'(wait_of(idx) + 1));
                chk($sformatf("prdata_%0d_a%0h", idx, got.addr), 32'(prdata[idx]), 32'(got.rdata));
                chk($sformatf("pslverr_%0d_a%0h", idx, got.addr), 32'(pslverr[idx]), 32'(got.err));
                if (got.wr && !got.err) model_mem[idx][got.addr[5:0]] = got.wdata;
                if (!got.wr) last_rd[idx] = got.rdata;
                done = 1'b1;
            end else begin
                chk($sformatf("wait_pslverr_%0d", idx), 32'(pslverr[idx]), 32'd0);
                cyc++;
                if (cyc > 20) begin
                    checks++;
                    assert (cyc <= 20) else begin
                        fails++;
                        $error("FAIL timeout_%0d: observed no PREADY after %0d cycles expected %0d", idx, cyc, wait_of(idx) + 1);
                    end
                    void'(sb.pop_front());
                    done = 1'b1;
                end
            end
            @(posedge PCLK); #1;
        end
        if (!b2b) begin
            psel[idx] = 1'b0;
            PENABLE   = 1'b0;
            @(negedge PCLK);
            chk($sformatf("ready_drop_%0d", idx), 32'(pready[idx]), 32'd0);
            chk($sformatf("slverr_drop_%0d", idx), 32'(pslverr[idx]), 32'd0);
            @(posedge PCLK); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        PRESET  = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 8'h00;
        PWDATA  = 8'h00;
        for (int d = 0; d < NDUT; d++) psel[d] = 1'b0;
        model_clear();

        // Reset state
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        chk_all_zero("reset");
        @(posedge PCLK); #1;

        // Read of a cleared word
        xfer(I1, 1'b0, 8'h05, 8'h00, 1'b0);

        // One wait state: write then read back
        xfer(I1, 1'b1, 8'h10, 8'h3C, 1'b0);
        xfer(I1, 1'b0, 8'h10, 8'h00, 1'b0);

        // Zero wait, back-to-back with no IDLE between transfers
        xfer(I0, 1'b1, 8'h00, 8'hA1, 1'b1);
        xfer(I0, 1'b1, 8'h01, 8'hB2, 1'b1);
        xfer(I0, 1'b0, 8'h00, 8'h00, 1'b1);
        xfer(I0, 1'b0, 8'h01, 8'h00, 1'b0);

        // Out-of-range write and read; 0x40 must not alias onto word 0
        xfer(I1, 1'b1, 8'h40, 8'h77, 1'b0);
        xfer(I1, 1'b0, 8'h40, 8'h00, 1'b0);
        xfer(I1, 1'b0, 8'h00, 8'h00, 1'b0);
        xfer(I1, 1'b0, 8'h10, 8'h00, 1'b0);

        // Three wait states: abort a write by dropping PSEL in the 2nd wait cycle
        xfer(I3, 1'b1, 8'h08, 8'h11, 1'b0);
        psel[I3] = 1'b1;
        PENABLE  = 1'b0;
        PWRITE   = 1'b1;
        PADDR    = 8'h08;
        PWDATA   = 8'h55;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        chk("abort_wait1_ready", 32'(pready[I3]), 32'd0);
        @(posedge PCLK); #1;
        psel[I3] = 1'b0;
        PENABLE  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge PCLK);
            chk($sformatf("abort_noready_%0d", k), 32'(pready[I3]), 32'd0);
        end
        @(posedge PCLK); #1;
        xfer(I3, 1'b0, 8'h08, 8'h00, 1'b0);

        // Reset mid-ACCESS of a write: nothing committed, outputs and memory cleared
        xfer(I3, 1'b1, 8'h02, 8'h5A, 1'b0);
        psel[I3] = 1'b1;
        PENABLE  = 1'b0;
        PWRITE   = 1'b1;
        PADDR    = 8'h02;
        PWDATA   = 8'h99;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET   = 1'b0;
        psel[I3] = 1'b0;
        PENABLE  = 1'b0;
        model_clear();
        @(negedge PCLK);
        chk_all_zero("midreset");
        @(posedge PCLK); #1;
        xfer(I3, 1'b0, 8'h02, 8'h00, 1'b0);
        xfer(I1, 1'b0, 8'h10, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
